// File: rtl/cbus_arbiter_if.sv
// rtl/cbus_arbiter_if.sv - cbus request/response types and the arbiter's grouped bus interface
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [31:0] data;
        logic [3:0]  strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

interface cbus_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    import cbus_pkg::*;

    cbus_req_t  ireqs  [NUM_PORTS];
    cbus_resp_t iresps [NUM_PORTS];
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    modport slave  (input ireqs, oresp, output iresps, oreq);
    modport master (output ireqs, oresp, input iresps, oreq);
endinterface

// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - cbus burst arbiter (port 0 DCache, port 1 ICache); CBUS_ARB_RR_EN selects round-robin
module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int CNT_BITS  = 4
) (
    input  logic          clk,
    input  logic          resetn,
    cbus_arbiter_if.slave bus,
    output logic          proto_err
);
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = CNT_BITS + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       grant, grant_nxt;
    logic [GW-1:0]       winner;
    logic                win_found;
    logic [CNT_BITS-1:0] beat_cnt, beat_cnt_nxt;
    logic [3:0]          burst_len, burst_len_nxt;
    logic                proto_err_nxt;
    logic [CW-1:0]       beats_done, beats_exp;
    logic                busy;

`ifdef CBUS_ARB_RR_EN
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] scan_idx;

    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (int'(rr_ptr) + k >= NUM_PORTS)
                scan_idx = GW'(int'(rr_ptr) + k - NUM_PORTS);
            else
                scan_idx = GW'(int'(rr_ptr) + k);
            if (!win_found && bus.ireqs[scan_idx].valid) begin
                winner    = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            rr_ptr <= '0;
        else if (state == BUSY && bus.oresp.ready && bus.oresp.last)
            rr_ptr <= (grant == GW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
    end
`else
    // Descending scan so the lowest-index valid port is the last one written.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (bus.ireqs[k].valid) begin
                winner    = GW'(k);
                win_found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            grant     <= '0;
            beat_cnt  <= '0;
            burst_len <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            beat_cnt  <= beat_cnt_nxt;
            burst_len <= burst_len_nxt;
            proto_err <= proto_err_nxt;
        end
    end

    // Length is captured at grant so an aborting master cannot disturb the beat check.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        beat_cnt_nxt  = beat_cnt;
        burst_len_nxt = burst_len;
        proto_err_nxt = proto_err;
        beats_done    = CW'(beat_cnt) + CW'(1);
        beats_exp     = CW'(burst_len) + CW'(1);
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt     = BUSY;
                    grant_nxt     = winner;
                    beat_cnt_nxt  = '0;
                    burst_len_nxt = bus.ireqs[winner].len;
                end
            end
            BUSY: begin
                if (bus.oresp.ready) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (bus.oresp.last) begin
                        state_nxt = IDLE;
                        if (beats_done != beats_exp)
                            proto_err_nxt = 1'b1;
                    end else if (beats_done == beats_exp) begin
                        proto_err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are also gated by resetn so nothing leaks while reset is held.
    assign busy = resetn && (state == BUSY);

    always_comb begin
        bus.oreq = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            bus.iresps[i] = '0;
        if (busy) begin
            bus.oreq          = bus.ireqs[grant];
            bus.iresps[grant] = bus.oresp;
        end
    end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb/tb_cbus_arbiter.sv - table, directed and randomized self-checking bench for cbus_arbiter
module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam logic [3:0] MLEN1 = 4'd0, MLEN2 = 4'd1, MLEN4 = 4'd3, MLEN8 = 4'd7, MLEN16 = 4'd15;

    logic clk = 1'b0;
    logic resetn;
    logic proto_err;
    int   n_cmp = 0;
    int   n_bad = 0;

    cbus_arbiter_if #(.NUM_PORTS(2)) bus();

    cbus_arbiter #(.NUM_PORTS(2), .CNT_BITS(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        port;
        cbus_req_t req;
        int        nbeats;
        bit        exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic chk_req(input string name, input cbus_req_t act, input cbus_req_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_resp(input string name, input cbus_resp_t act, input cbus_resp_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic cbus_req_t mk_req(input bit w, input logic [31:0] a, input logic [3:0] l,
                                         input logic [31:0] d, input logic [3:0] s);
        mk_req = '{valid: 1'b1, is_write: w, addr: a, len: l, data: d, strobe: s};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        resetn       = 1'b0;
        bus.ireqs[0] = '0;
        bus.ireqs[1] = '0;
        bus.oresp    = '0;
        tick;
        resetn = 1'b1;
    endtask

    // Memory gives n ready beats, last on the final one; the master then drops its request.
    task automatic give_beats(input int port, input int n);
        cbus_resp_t r;
        for (int b = 1; b <= n; b++) begin
            r = '{ready: 1'b1, last: (b == n), data: $urandom};
            bus.oresp = r;
            settle;
            chk_resp($sformatf("beat%0d_route_p%0d", b, port), bus.iresps[port], r);
            chk_resp($sformatf("beat%0d_quiet_p%0d", b, 1 - port), bus.iresps[1 - port], '0);
            tick;
        end
        bus.oresp       = '0;
        bus.ireqs[port] = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        tick;
        bus.ireqs[v.port] = v.req;
        settle;
        chk_bit($sformatf("v%0d_bubble", idx), bus.oreq.valid, 1'b0);
        tick;
        settle;
        chk_req($sformatf("v%0d_fwd", idx), bus.oreq, v.req);
        give_beats(v.port, v.nbeats);
        settle;
        chk_bit($sformatf("v%0d_idle_after", idx), bus.oreq.valid, 1'b0);
        chk_bit($sformatf("v%0d_err", idx), proto_err, v.exp_err);
        tick;
        settle;
        chk_bit($sformatf("v%0d_err_hold", idx), proto_err, v.exp_err);
        if (v.exp_err) begin
            do_reset;
            settle;
            chk_bit($sformatf("v%0d_err_cleared", idx), proto_err, 1'b0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cbus_req_t  ra, rb, ra2, rc, rd;
        cbus_req_t  mreq [2];
        bit         active [2];
        cbus_resp_t exp_rsp [2];
        cbus_req_t  exp_req;
        cbus_resp_t r;
        logic [3:0] lens [5];
        int         owner, next_start, beats, blen, start, w;
        bit         err, rdy, lst, rst_cyc;

        lens = '{MLEN1, MLEN2, MLEN4, MLEN8, MLEN16};

        vecs[0] = '{port: 1, req: mk_req(1'b0, 32'h1000, MLEN4, 32'h0, 4'h0), nbeats: 4, exp_err: 1'b0};
        vecs[1] = '{port: 0, req: mk_req(1'b1, 32'h2000, MLEN1, 32'hdeadbeef, 4'b0011), nbeats: 1, exp_err: 1'b0};
        vecs[2] = '{port: 0, req: mk_req(1'b0, 32'h2040, MLEN16, 32'h0, 4'h0), nbeats: 16, exp_err: 1'b0};
        vecs[3] = '{port: 1, req: mk_req(1'b0, 32'h1100, MLEN4, 32'h0, 4'h0), nbeats: 2, exp_err: 1'b1};
        vecs[4] = '{port: 0, req: mk_req(1'b1, 32'h2200, MLEN1, 32'h12345678, 4'hf), nbeats: 2, exp_err: 1'b1};
        vecs[5] = '{port: 1, req: mk_req(1'b0, 32'h1800, MLEN8, 32'h0, 4'h0), nbeats: 8, exp_err: 1'b0};
        vecs[6] = '{port: 0, req: mk_req(1'b1, 32'h2300, MLEN2, 32'hcafef00d, 4'b1100), nbeats: 3, exp_err: 1'b1};

        resetn       = 1'b0;
        bus.ireqs[0] = '0;
        bus.ireqs[1] = '0;
        bus.oresp    = '0;
        tick;
        tick;
        settle;
        chk_req("reset_oreq", bus.oreq, '0);
        chk_resp("reset_iresp0", bus.iresps[0], '0);
        chk_resp("reset_iresp1", bus.iresps[1], '0);
        chk_bit("reset_proto_err", proto_err, 1'b0);
        resetn = 1'b1;
        tick;
        settle;
        chk_req("after_reset_oreq", bus.oreq, '0);
        chk_bit("after_reset_proto_err", proto_err, 1'b0);

        for (int i = 0; i < 7; i++)
            run_vec(i, vecs[i]);

        // Contention: both valid, then port0 re-requests on the gap cycle.
        do_reset;
        ra  = mk_req(1'b0, 32'h3000, MLEN2, 32'h0, 4'h0);
        rb  = mk_req(1'b0, 32'h4000, MLEN2, 32'h0, 4'h0);
        ra2 = mk_req(1'b1, 32'h5000, MLEN1, 32'hdeadbeef, 4'b0011);
        tick;
        bus.ireqs[0] = ra;
        bus.ireqs[1] = rb;
        settle;
        chk_bit("cont_bubble", bus.oreq.valid, 1'b0);
        tick;
        settle;
        chk_req("cont_first_p0", bus.oreq, ra);
        give_beats(0, 2);
        bus.ireqs[0] = ra2;
        settle;
        chk_bit("cont_gap", bus.oreq.valid, 1'b0);
`ifdef CBUS_ARB_RR_EN
        w = 1;
`else
        w = 0;
`endif
        tick;
        settle;
        chk_req("cont_second", bus.oreq, (w == 1) ? rb : ra2);
        give_beats(w, (w == 1) ? 2 : 1);
        settle;
        chk_bit("cont_gap2", bus.oreq.valid, 1'b0);
        tick;
        settle;
        chk_req("cont_third", bus.oreq, (w == 1) ? ra2 : rb);
        give_beats(1 - w, (w == 1) ? 1 : 2);
        settle;
        chk_bit("cont_err", proto_err, 1'b0);

        // Port1 arrives on port0's completion cycle.
        do_reset;
        ra = mk_req(1'b0, 32'h6000, MLEN1, 32'h0, 4'h0);
        rc = mk_req(1'b0, 32'h7000, MLEN1, 32'h0, 4'h0);
        tick;
        bus.ireqs[0] = ra;
        settle;
        tick;
        settle;
        chk_req("cmpl_fwd", bus.oreq, ra);
        bus.ireqs[1] = rc;
        bus.oresp    = '{ready: 1'b1, last: 1'b1, data: 32'h0};
        settle;
        chk_req("cmpl_cycle_oreq", bus.oreq, ra);
        tick;
        bus.ireqs[0] = '0;
        bus.oresp    = '0;
        settle;
        chk_bit("cmpl_idle", bus.oreq.valid, 1'b0);
        tick;
        settle;
        chk_req("cmpl_next_p1", bus.oreq, rc);
        give_beats(1, 1);

        // Master abort: valid drops but the grant holds until memory's last.
        do_reset;
        rd = mk_req(1'b0, 32'h8000, MLEN4, 32'h0, 4'h0);
        tick;
        bus.ireqs[1] = rd;
        settle;
        tick;
        settle;
        chk_req("abort_fwd", bus.oreq, rd);
        tick;
        bus.ireqs[1].valid = 1'b0;
        settle;
        chk_bit("abort_follow", bus.oreq.valid, 1'b0);
        give_beats(1, 4);
        settle;
        chk_bit("abort_idle", bus.oreq.valid, 1'b0);
        chk_bit("abort_err", proto_err, 1'b0);

        // Sticky error, then reset in the middle of a burst.
        do_reset;
        tick;
        bus.ireqs[0] = mk_req(1'b0, 32'h9000, MLEN1, 32'h0, 4'h0);
        settle;
        tick;
        settle;
        give_beats(0, 2);
        settle;
        chk_bit("sticky_a", proto_err, 1'b1);
        tick;
        settle;
        chk_bit("sticky_b", proto_err, 1'b1);
        tick;
        bus.ireqs[0] = mk_req(1'b0, 32'h9100, MLEN4, 32'h0, 4'h0);
        settle;
        tick;
        bus.oresp = '{ready: 1'b1, last: 1'b0, data: 32'h1};
        settle;
        tick;
        bus.oresp = '{ready: 1'b1, last: 1'b0, data: 32'h2};
        resetn    = 1'b0;
        settle;
        chk_req("rst_held_oreq", bus.oreq, '0);
        tick;
        resetn       = 1'b1;
        bus.ireqs[0] = '0;
        bus.oresp    = '0;
        settle;
        chk_req("rst_mid_oreq", bus.oreq, '0);
        chk_resp("rst_mid_iresp0", bus.iresps[0], '0);
        chk_resp("rst_mid_iresp1", bus.iresps[1], '0);
        chk_bit("rst_mid_proto_err", proto_err, 1'b0);

        // Randomized traffic against a burst-level reference model.
        do_reset;
        owner      = -1;
        next_start = 0;
        beats      = 0;
        blen       = 0;
        err        = 1'b0;
        active     = '{1'b0, 1'b0};
        mreq       = '{'0, '0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_cyc = (cyc % 250 == 249);
            tick;
            resetn = !rst_cyc;
            for (int i = 0; i < 2; i++) begin
                if (!active[i] && !rst_cyc && $urandom_range(0, 3) == 0) begin
                    mreq[i]   = mk_req(1'($urandom_range(0, 1)), $urandom, lens[$urandom_range(0, 4)],
                                       $urandom, 4'($urandom_range(0, 15)));
                    active[i] = 1'b1;
                end
                bus.ireqs[i] = active[i] ? mreq[i] : '0;
            end
            rdy = 1'($urandom_range(0, 1));
            if (owner >= 0)
                lst = ((beats + 1) == (blen + 1)) ^ ($urandom_range(0, 31) == 0);
            else
                lst = 1'($urandom_range(0, 1));
            r = '{ready: rdy, last: lst, data: $urandom};
            bus.oresp = r;
            settle;

            exp_req    = '0;
            exp_rsp[0] = '0;
            exp_rsp[1] = '0;
            if (owner >= 0 && !rst_cyc) begin
                exp_req        = mreq[owner];
                exp_rsp[owner] = r;
            end
            chk_req($sformatf("rnd%0d_oreq", cyc), bus.oreq, exp_req);
            chk_resp($sformatf("rnd%0d_iresp0", cyc), bus.iresps[0], exp_rsp[0]);
            chk_resp($sformatf("rnd%0d_iresp1", cyc), bus.iresps[1], exp_rsp[1]);
            chk_bit($sformatf("rnd%0d_proto_err", cyc), proto_err, err);

            if (rst_cyc) begin
                owner      = -1;
                next_start = 0;
                beats      = 0;
                err        = 1'b0;
                active     = '{1'b0, 1'b0};
            end else if (owner < 0) begin
`ifdef CBUS_ARB_RR_EN
                start = next_start;
`else
                start = 0;
`endif
                for (int k = 0; k < 2; k++) begin
                    if (owner < 0 && active[(start + k) % 2]) begin
                        owner = (start + k) % 2;
                        beats = 0;
                        blen  = int'(mreq[owner].len);
                    end
                end
            end else if (rdy) begin
                beats++;
                if (lst) begin
                    if (beats != blen + 1)
                        err = 1'b1;
                    active[owner] = 1'b0;
                    next_start    = (owner + 1) % 2;
                    owner         = -1;
                end else if (beats == blen + 1) begin
                    err = 1'b1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
